vga_sync: RTL and testbench
===========================

# vga_sync

Generates 640x480 at 60 Hz VGA raster timing for the display path. It sits directly downstream of `clockdiv`, in the system clock domain, and advances one pixel per cycle of a single-cycle pixel-enable strobe derived from `pclk`. It produces `hsync`, `vsync`, the pixel coordinates, a visible-area flag, and line/frame start pulses for the pixel-generation logic downstream.

## Interface
Parameters:
- `H_VIS`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync pulse width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_VIS`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync pulse width, in lines
- `V_BP`, 33: vertical back porch, in lines

Ports:
- `clk`  in  1: system clock, the same clock that feeds `clockdiv`.
- `clr`  in  1: reset; synchronous, active-high.
- `pix_en`  in  1: one-cycle pixel strobe, one pulse per `pclk` period. Held high means advance every `clk`.
- `hc`  out  10: horizontal pixel count, 0..H_TOT-1.
- `vc`  out  10: line count, 0..V_TOT-1.
- `hsync`  out  1: horizontal sync, active-low.
- `vsync`  out  1: vertical sync, active-low.
- `active`  out  1: high when `hc < H_VIS` and `vc < V_VIS`.
- `line_start`  out  1: one-`clk` pulse on the cycle `hc` becomes 0.
- `frame_start`  out  1: one-`clk` pulse on the cycle `hc` and `vc` both become 0.

## Operation
- Derived totals:
  - H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 800.
  - V_TOT = V_VIS+V_FP+V_SYNC+V_BP = 525.
- Horizontal phase FSM, with state held alongside `hc`:
  - ACTIVE, for hc 0..639
  - FRONT, for 640..655
  - SYNC, for 656..751
  - BACK, for 752..799
  - BACK goes to ACTIVE on wrap.
- The vertical phase FSM has the same four states, indexed by `vc`: 0..479, 480..489, 490..491, 492..524.
- On a `clk` edge with `pix_en`=1:
  - `hc` increments.
  - At H_TOT-1, `hc` wraps to 0 and `vc` increments.
  - `vc` wraps to 0 at V_TOT-1, but only on the same edge that `hc` wraps.
- With `pix_en`=0, all state holds. `line_start` and `frame_start` deassert.
- All outputs are registered and computed from next-state counters, so that `hsync`, `vsync` and `active` always agree with the `hc`/`vc` values presented in the same cycle. There is no pipeline skew between them.
- `hsync`=0 exactly while the horizontal state is SYNC. `vsync`=0 exactly while the vertical state is SYNC; it changes only on `hc` wrap edges.
- Reset values:
  - `hc`=799, `vc`=524, both FSMs in BACK.
  - `hsync`=1, `vsync`=1, `active`=0, `line_start`=0, `frame_start`=0.
  - Consequence: the first `pix_en` after reset produces pixel (0,0) with `frame_start`=1.
- Reset has priority over `pix_en` when both are asserted in the same cycle.
- Reset asserted mid-frame returns to the reset state on the next edge; no partial line completes.
- Counters are 10-bit unsigned. No value outside 0..H_TOT-1 or 0..V_TOT-1 is ever presented.

## Timing
- Latency from a `pix_en` edge to the updated `hc`/`vc`/sync/`active` outputs is 1 `clk`.
- Line period: 800 `pix_en` pulses. Frame period: 420 000 `pix_en` pulses.
- `line_start` and `frame_start` are high for exactly one `clk`, even if `pix_en` stays high.
- `pix_en` has no ready/valid handshake. Every pulse is consumed unconditionally.

## Structure
- Shared package `vga_pkg` holds:
  - default timing constants, with derived H_TOT and V_TOT;
  - the phase enum (ACTIVE, FRONT, SYNC, BACK);
  - a 10-bit coordinate type.
  - `vga_sync` and downstream pixel logic both import it.
- One sub-module, `sync_axis`, instantiated twice (horizontal and vertical):
  - Parameters: VIS, FP, SYNC, BP.
  - Inputs: `clk`, `clr`, `adv`.
  - Outputs: `cnt`, phase, `sync_n`, `vis`, `wrap`.
  - The vertical instance's `adv` = horizontal `wrap` AND `pix_en`.

## Test plan
- Reset, then a single `pix_en` pulse → `hc`=0, `vc`=0, `active`=1, `frame_start`=1 for one cycle, `hsync`=`vsync`=1.
- `pix_en` tied high for 800 cycles → `hsync` low for cycles where hc=656..751 (96 cycles). `line_start` re-pulses as hc returns to 0 with `vc`=1.
- Full frame at `pix_en` every 4th `clk` → exactly 420 000 pulses between consecutive `frame_start` pulses. `vsync` low for lines 490..491 (1600 pixels). `active` high for 307 200 pulses.
- At `hc`=799, `vc`=524, apply `pix_en` → both counters wrap to 0 in the same cycle; `line_start`=`frame_start`=1.
- `clr` asserted together with `pix_en` at hc=300, vc=200 → next cycle `hc`=799, `vc`=524, `active`=0, with no wrap pulse.
- `pix_en` held low for 1000 cycles mid-line → every output stays constant.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, axis phase enum and coordinate type.
// The same definitions are used by vga_sync and the downstream pixel logic.
package vga_pkg;

    localparam int H_VIS_D  = 640;
    localparam int H_FP_D   = 16;
    localparam int H_SYNC_D = 96;
    localparam int H_BP_D   = 48;
    localparam int H_TOT_D  = H_VIS_D + H_FP_D + H_SYNC_D + H_BP_D;

    localparam int V_VIS_D  = 480;
    localparam int V_FP_D   = 10;
    localparam int V_SYNC_D = 2;
    localparam int V_BP_D   = 33;
    localparam int V_TOT_D  = V_VIS_D + V_FP_D + V_SYNC_D + V_BP_D;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/sync_axis.sv
// One raster axis: counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Flags are registered from next-state so they line up with the presented count.
module sync_axis
    import vga_pkg::*;
#(
    parameter int VIS  = H_VIS_D,
    parameter int FP   = H_FP_D,
    parameter int SYNC = H_SYNC_D,
    parameter int BP   = H_BP_D
) (
    input  logic   clk,
    input  logic   clr,
    input  logic   adv,
    output coord_t cnt,
    output phase_t phase,
    output logic   sync_n,
    output logic   vis,
    output logic   wrap
);

    localparam coord_t LAST     = coord_t'(VIS + FP + SYNC + BP - 1);
    localparam coord_t FP_START = coord_t'(VIS);
    localparam coord_t SY_START = coord_t'(VIS + FP);
    localparam coord_t BP_START = coord_t'(VIS + FP + SYNC);

    coord_t r_cnt;
    coord_t w_cnt_nxt;
    phase_t r_phase;
    phase_t w_phase_nxt;
    logic   r_sync_n;
    logic   r_vis;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt    <= LAST;
            r_phase  <= PH_BACK;
            r_sync_n <= 1'b1;
            r_vis    <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_phase  <= w_phase_nxt;
            r_sync_n <= (w_phase_nxt != PH_SYNC);
            r_vis    <= (w_phase_nxt == PH_ACTIVE);
        end
    end

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        if (adv) begin
            w_cnt_nxt = wrap ? '0 : r_cnt + 1'b1;
            unique case (r_phase)
                PH_ACTIVE: if (w_cnt_nxt == FP_START) w_phase_nxt = PH_FRONT;
                PH_FRONT:  if (w_cnt_nxt == SY_START) w_phase_nxt = PH_SYNC;
                PH_SYNC:   if (w_cnt_nxt == BP_START) w_phase_nxt = PH_BACK;
                PH_BACK:   if (wrap)                  w_phase_nxt = PH_ACTIVE;
                default:                              w_phase_nxt = PH_BACK;
            endcase
        end
    end

    // wrap is combinational: it qualifies the advance that rolls the count over
    assign wrap   = (r_cnt == LAST);
    assign cnt    = r_cnt;
    assign phase  = r_phase;
    assign sync_n = r_sync_n;
    assign vis    = r_vis;

endmodule

// File: rtl/vga_sync.sv
// 640x480@60 raster timing generator advanced by a one-cycle pixel strobe.
// The vertical axis only steps on the pixel strobe that wraps the horizontal axis.
module vga_sync
    import vga_pkg::*;
#(
    parameter int H_VIS  = H_VIS_D,
    parameter int H_FP   = H_FP_D,
    parameter int H_SYNC = H_SYNC_D,
    parameter int H_BP   = H_BP_D,
    parameter int V_VIS  = V_VIS_D,
    parameter int V_FP   = V_FP_D,
    parameter int V_SYNC = V_SYNC_D,
    parameter int V_BP   = V_BP_D
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       pix_en,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       line_start,
    output logic       frame_start
);

    coord_t w_hc;
    coord_t w_vc;
    phase_t w_h_phase;
    phase_t w_v_phase;
    logic   w_h_sync_n;
    logic   w_v_sync_n;
    logic   w_h_vis;
    logic   w_v_vis;
    logic   w_h_wrap;
    logic   w_v_wrap;
    logic   w_v_adv;
    logic   r_line_start;
    logic   r_frame_start;

    assign w_v_adv = pix_en & w_h_wrap;

    sync_axis #(.VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
        .clk    (clk),
        .clr    (clr),
        .adv    (pix_en),
        .cnt    (w_hc),
        .phase  (w_h_phase),
        .sync_n (w_h_sync_n),
        .vis    (w_h_vis),
        .wrap   (w_h_wrap)
    );

    sync_axis #(.VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
        .clk    (clk),
        .clr    (clr),
        .adv    (w_v_adv),
        .cnt    (w_vc),
        .phase  (w_v_phase),
        .sync_n (w_v_sync_n),
        .vis    (w_v_vis),
        .wrap   (w_v_wrap)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_v_adv;
            r_frame_start <= w_v_adv & w_v_wrap;
        end
    end

    // Registered flags must always agree with the phase they were decoded from
    a_h_phase: assert property (@(posedge clk) disable iff (clr)
        (w_h_vis == (w_h_phase == PH_ACTIVE)) && (w_h_sync_n == (w_h_phase != PH_SYNC)));
    a_v_phase: assert property (@(posedge clk) disable iff (clr)
        (w_v_vis == (w_v_phase == PH_ACTIVE)) && (w_v_sync_n == (w_v_phase != PH_SYNC)));

    assign hc          = w_hc;
    assign vc          = w_vc;
    assign hsync       = w_h_sync_n;
    assign vsync       = w_v_sync_n;
    assign active      = w_h_vis & w_v_vis;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default-geometry instance and a shrunk-geometry instance
// checked every cycle against a pulse-count raster model.
module tb_vga_sync;

    localparam int HV_S = 20, HF_S = 3, HS_S = 5, HB_S = 4;
    localparam int VV_S = 12, VF_S = 2, VS_S = 2, VB_S = 3;
    localparam int HT_S = HV_S + HF_S + HS_S + HB_S;
    localparam int VT_S = VV_S + VF_S + VS_S + VB_S;
    localparam int FT_S = HT_S * VT_S;

    typedef struct packed {
        logic [9:0] hc;
        logic [9:0] vc;
        logic       hs;
        logic       vs;
        logic       act;
        logic       ls;
        logic       fs;
    } obs_t;

    logic clk = 1'b0;
    logic clr_s = 1'b1, pix_en_s = 1'b0;
    logic clr_f = 1'b1, pix_en_f = 1'b0;
    logic [9:0] hc_s, vc_s, hc_f, vc_f;
    logic hsync_s, vsync_s, active_s, ls_s, fs_s;
    logic hsync_f, vsync_f, active_f, ls_f, fs_f;

    int vec = 0;
    int err = 0;
    longint n_s = 0, n_f = 0;
    bit pul_s = 0, pul_f = 0;

    always #5 clk = ~clk;

    vga_sync #(.H_VIS(HV_S), .H_FP(HF_S), .H_SYNC(HS_S), .H_BP(HB_S),
               .V_VIS(VV_S), .V_FP(VF_S), .V_SYNC(VS_S), .V_BP(VB_S)) u_small (
        .clk(clk), .clr(clr_s), .pix_en(pix_en_s), .hc(hc_s), .vc(vc_s),
        .hsync(hsync_s), .vsync(vsync_s), .active(active_s),
        .line_start(ls_s), .frame_start(fs_s)
    );

    vga_sync u_full (
        .clk(clk), .clr(clr_f), .pix_en(pix_en_f), .hc(hc_f), .vc(vc_f),
        .hsync(hsync_f), .vsync(vsync_f), .active(active_f),
        .line_start(ls_f), .frame_start(fs_f)
    );

    obs_t obs_s, obs_f;
    assign obs_s = {hc_s, vc_s, hsync_s, vsync_s, active_s, ls_s, fs_s};
    assign obs_f = {hc_f, vc_f, hsync_f, vsync_f, active_f, ls_f, fs_f};

    // n pulses after reset presents raster index n-1 (index -1 == last pixel of frame)
    function automatic obs_t model(input int hv, hf, hs, hb, vv, vf, vs, vb,
                                   input longint n, input bit pulsed);
        int ht, vt, idx, h, v;
        longint ft;
        obs_t o;
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        ft  = longint'(ht) * longint'(vt);
        idx = int'((n + ft - 1) % ft);
        h   = idx % ht;
        v   = idx / ht;
        o.hc  = 10'(h);
        o.vc  = 10'(v);
        o.hs  = !(h >= hv + hf && h < hv + hf + hs);
        o.vs  = !(v >= vv + vf && v < vv + vf + vs);
        o.act = (h < hv) && (v < vv);
        o.ls  = pulsed && (h == 0);
        o.fs  = pulsed && (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic obs_t exp_s();
        return model(HV_S, HF_S, HS_S, HB_S, VV_S, VF_S, VS_S, VB_S, n_s, pul_s);
    endfunction

    function automatic obs_t exp_f();
        return model(640, 16, 96, 48, 480, 10, 2, 33, n_f, pul_f);
    endfunction

    task automatic tick(input bit es, input bit cs, input bit ef, input bit cf);
        pix_en_s = es; clr_s = cs;
        pix_en_f = ef; clr_f = cf;
        @(posedge clk);
        #1;
        if (cs) begin n_s = 0; pul_s = 0; end
        else begin pul_s = es; if (es) n_s++; end
        if (cf) begin n_f = 0; pul_f = 0; end
        else begin pul_f = ef; if (ef) n_f++; end
    endtask

    task automatic test_reset();
        obs_t e;
        tick(0, 1, 0, 1);
        vec++;
        e = {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        if (obs_f !== e) begin err++; $display("FAIL reset_full got %h want %h", obs_f, e); end
        vec++;
        if (obs_s !== exp_s()) begin err++; $display("FAIL reset_small got %h want %h", obs_s, exp_s()); end
        tick(1, 0, 1, 0);
        vec++;
        e = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        if (obs_f !== e) begin err++; $display("FAIL first_pixel_full got %h want %h", obs_f, e); end
        vec++;
        if (obs_s !== exp_s()) begin err++; $display("FAIL first_pixel_small got %h want %h", obs_s, exp_s()); end
        tick(0, 0, 0, 0);
        vec++;
        e = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        if (obs_f !== e) begin err++; $display("FAIL pulse_drop_full got %h want %h", obs_f, e); end
    endtask

    task automatic test_line_full();
        int hs_low = 0;
        int first_low = -1;
        for (int i = 0; i < 800; i++) begin
            tick(0, 0, 1, 0);
            vec++;
            if (obs_f !== exp_f()) begin err++; $display("FAIL line_full cyc %0d got %h want %h", i, obs_f, exp_f()); end
            if (!hsync_f) begin
                hs_low++;
                if (first_low < 0) first_low = int'(hc_f);
            end
        end
        vec++;
        if (hs_low != 96) begin err++; $display("FAIL hsync_width got %0d want 96", hs_low); end
        vec++;
        if (first_low != 656) begin err++; $display("FAIL hsync_start got %0d want 656", first_low); end
        vec++;
        if ({hc_f, vc_f, ls_f} !== {10'd0, 10'd1, 1'b1}) begin
            err++; $display("FAIL line_restart got hc=%0d vc=%0d ls=%b want hc=0 vc=1 ls=1", hc_f, vc_f, ls_f);
        end
    endtask

    task automatic test_frame_small();
        int pulses = 0, fs_seen = 0, fs_at0 = 0, fs_at1 = 0, vs_low = 0, act_cnt = 0;
        bit en;
        tick(0, 1, 0, 0);
        for (int i = 0; i < 4 * (FT_S + 8) && fs_seen < 2; i++) begin
            en = ((i % 4) == 3);
            tick(en, 0, 0, 0);
            vec++;
            if (obs_s !== exp_s()) begin err++; $display("FAIL frame_small cyc %0d got %h want %h", i, obs_s, exp_s()); end
            if (en) begin
                pulses++;
                if (fs_s) begin
                    if (fs_seen == 0) fs_at0 = pulses; else fs_at1 = pulses;
                    fs_seen++;
                end
                if (fs_seen == 1) begin
                    if (!vsync_s) vs_low++;
                    if (active_s) act_cnt++;
                end
            end
        end
        vec++;
        if (fs_seen != 2) begin err++; $display("FAIL frame_timeout got %0d frame_starts want 2", fs_seen); end
        vec++;
        if (fs_at1 - fs_at0 != FT_S) begin err++; $display("FAIL frame_period got %0d want %0d", fs_at1 - fs_at0, FT_S); end
        vec++;
        if (vs_low != VS_S * HT_S) begin err++; $display("FAIL vsync_pixels got %0d want %0d", vs_low, VS_S * HT_S); end
        vec++;
        if (act_cnt != HV_S * VV_S) begin err++; $display("FAIL active_pixels got %0d want %0d", act_cnt, HV_S * VV_S); end
    endtask

    task automatic test_wrap_small();
        obs_t e;
        for (int i = 0; i < FT_S + 2 && ((n_s + FT_S - 1) % FT_S) != FT_S - 1; i++) tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        vec++;
        if ({hc_s, vc_s} !== {10'(HT_S - 1), 10'(VT_S - 1)}) begin
            err++; $display("FAIL pre_wrap got hc=%0d vc=%0d want hc=%0d vc=%0d", hc_s, vc_s, HT_S - 1, VT_S - 1);
        end
        tick(1, 0, 0, 0);
        vec++;
        e = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        if (obs_s !== e) begin err++; $display("FAIL frame_wrap got %h want %h", obs_s, e); end
        tick(1, 0, 0, 0);
        vec++;
        if (ls_s !== 1'b0 || fs_s !== 1'b0) begin
            err++; $display("FAIL start_one_cycle got ls=%b fs=%b want 0 0", ls_s, fs_s);
        end
    endtask

    task automatic test_clr_mid();
        obs_t e;
        tick(0, 1, 0, 0);
        for (int i = 0; i < 5 * HT_S + 10 + 1; i++) tick(1, 0, 0, 0);
        vec++;
        if ({hc_s, vc_s} !== {10'd10, 10'd5}) begin err++; $display("FAIL clr_setup got hc=%0d vc=%0d want 10 5", hc_s, vc_s); end
        tick(1, 1, 0, 0);
        vec++;
        e = {10'(HT_S - 1), 10'(VT_S - 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        if (obs_s !== e) begin err++; $display("FAIL clr_priority got %h want %h", obs_s, e); end
    endtask

    task automatic test_hold_full();
        for (int i = 0; i < 100; i++) tick(0, 0, 1, 0);
        for (int i = 0; i < 1000; i++) begin
            tick(0, 0, 0, 0);
            vec++;
            if (obs_f !== exp_f()) begin err++; $display("FAIL hold cyc %0d got %h want %h", i, obs_f, exp_f()); end
        end
    endtask

    task automatic test_random_small();
        bit es, cs;
        for (int i = 0; i < 3000; i++) begin
            es = ($urandom % 3) != 0;
            cs = ($urandom % 200) == 0;
            tick(es, cs, 0, 0);
            vec++;
            if (obs_s !== exp_s()) begin err++; $display("FAIL random cyc %0d got %h want %h", i, obs_s, exp_s()); end
        end
    endtask

    initial begin
        test_reset();
        test_line_full();
        test_frame_small();
        test_wrap_small();
        test_clr_mid();
        test_hold_full();
        test_random_small();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
